// File: rtl/bench_eval_ctrl.sv
// Exhaustive-sweep controller for a combinational benchmark: drives every input
// pattern, compacts responses into a MISR (macro BENCH_EVAL_CTRL_MISR_EN) and counts onsets.
module bench_eval_ctrl #(
  parameter int unsigned W_IN      = 11,
  parameter int unsigned W_OUT     = 23,
  parameter int unsigned LAT       = 1,
  parameter int unsigned ONSET_BIT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [W_IN-1:0]  pat_out,
  output logic             pat_valid,
  input  logic [W_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
  output logic [W_IN:0]    onset_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [W_IN-1:0] cnt_q, cnt_d;
  logic [1:0]      drain_q, drain_d;
  logic [W_IN:0]   onset_q, onset_d;
  logic            cap_valid;
  logic            capture;
  logic            kill;
  logic            seed;

  assign pat_valid = (state_q == RUN);
  assign pat_out   = pat_valid ? cnt_q : '0;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign onset_cnt = onset_q;
  assign seed      = (state_q == IDLE) && start && !abort;
  assign kill      = busy && abort;
  // The response arriving in the abort cycle is dropped with the rest of the sweep.
  assign capture   = cap_valid && !kill;

  if (LAT == 0) begin : g_nolat
    assign cap_valid = pat_valid;
  end else begin : g_lat
    logic [LAT-1:0] vpipe_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vpipe_q <= '0;
      end else if (kill) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= (vpipe_q << 1) | LAT'(pat_valid);
      end
    end
    assign cap_valid = vpipe_q[LAT-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    onset_d = onset_q;
    if (capture && resp_in[ONSET_BIT]) begin
      onset_d = onset_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (seed) begin
          state_d = RUN;
          cnt_d   = '0;
          onset_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '1) begin
          if (LAT == 0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            drain_d = 2'(LAT - 1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (drain_q == 2'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      onset_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      onset_q <= onset_d;
    end
  end

`ifdef BENCH_EVAL_CTRL_MISR_EN
  localparam logic [31:0] POLY = 32'h0040_0007;

  logic [31:0] resp_ext;
  logic [31:0] sig_q, sig_d;

  if (W_OUT >= 32) begin : g_wide
    assign resp_ext = resp_in[31:0];
  end else begin : g_narrow
    assign resp_ext = {{(32 - W_OUT){1'b0}}, resp_in};
  end

  always_comb begin
    sig_d = sig_q;
    if (seed) begin
      sig_d = '1;
    end else if (capture) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : '0) ^ resp_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: doc/bench_eval_ctrl.md
BENCH_EVAL_CTRL -- requirements
Module: bench_eval_ctrl

Interface
REQ-001 Parameter W_IN, default 11: width of the pattern vector driven to the combinational benchmark under test.
REQ-002 Parameter W_OUT, default 23: width of the benchmark response vector.
REQ-003 Parameter LAT, default 1, legal range 0..3: registered pipeline depth between pat_out and resp_in.
REQ-004 Parameter ONSET_BIT, default 7: index of the response bit counted by onset_cnt.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-008 abort  input  1  terminate a sweep in progress.
REQ-009 pat_out  output  W_IN  pattern applied to the benchmark inputs x0..x(W_IN-1).
REQ-010 pat_valid  output  1  pat_out carries a live pattern this cycle.
REQ-011 resp_in  input  W_OUT  benchmark outputs f1..f(W_OUT), bit 0 = f1.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 signature  output  32  MISR result; held stable outside RUN/DRAIN.
REQ-015 onset_cnt  output  W_IN+1  count of captured responses with resp_in[ONSET_BIT]=1.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE, start=1 with abort=0 SHALL seed signature to 0xFFFFFFFF, clear onset_cnt and the pattern counter, and go to RUN.
REQ-018 In RUN, pat_valid SHALL be 1 and pat_out SHALL equal the counter, incrementing by 1 per cycle from 0 to 2^W_IN-1.
REQ-019 After the cycle presenting 2^W_IN-1, the FSM SHALL go to DRAIN for exactly LAT cycles; when LAT=0 it SHALL go directly to DONE.
REQ-020 pat_valid SHALL be delayed through a LAT-stage shift register; resp_in SHALL be captured only in cycles where the delayed valid is 1.
REQ-021 On each capture, signature SHALL become {sig[30:0],0} XOR (sig[31] ? 0x00400007 : 0) XOR zero-extended resp_in.
REQ-022 On each capture with resp_in[ONSET_BIT]=1, onset_cnt SHALL increment by 1; it SHALL not wrap, since its maximum is 2^W_IN.
REQ-023 DONE SHALL last one cycle, assert done, then return to IDLE.
REQ-024 Latency: done SHALL be high exactly 2^W_IN+LAT+1 cycles after the edge that samples start.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 abort in RUN or DRAIN SHALL go to IDLE at the next edge, drop busy and pat_valid, and flush the valid pipeline.
REQ-027 After an abort, done SHALL not pulse, and signature and onset_cnt SHALL hold their partial values.
REQ-028 If start and abort are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 Outside RUN, pat_out SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and set pat_out=0, pat_valid=0, busy=0, done=0, signature=0, onset_cnt=0, and clear the valid pipeline, including mid-sweep.
REQ-031 After rst deasserts, the first action SHALL be a start sampled in IDLE.

Configuration
REQ-032 Macro BENCH_EVAL_CTRL_MISR_EN defined: the MISR SHALL be built as in REQ-021.
REQ-033 Macro BENCH_EVAL_CTRL_MISR_EN undefined: the MISR logic SHALL be absent and signature tied to 0; FSM, pat_out and onset_cnt SHALL be unchanged.

Verification
REQ-034 LAT=1, resp_in tied 0, start pulse -> pat_out steps 0..2047, done at cycle 2050, onset_cnt=0, signature equals the reference-model value for 2048 zero shifts from 0xFFFFFFFF.
REQ-035 LAT=1, resp_in[7]=delayed pat_out[0], all other bits 0 -> onset_cnt=1024 at done.
REQ-036 LAT=2, resp_in[7]=1 constant -> onset_cnt=2048, done at cycle 2051, no overflow.
REQ-037 abort while pat_out=100 -> busy=0 and pat_out=0 next cycle, done never pulses, onset_cnt holds.
REQ-038 start repeated at pat_out=5 -> ignored, sweep completes normally; rst at pat_out=300 -> all outputs 0 within the same cycle, and a later start runs a full sweep.
REQ-039 Macro undefined, rerun REQ-034 stimulus -> signature=0 throughout, done timing identical.
